// File: rtl/rex_pkg.sv
// Shared definitions for the obstacle scheduler: FSM encoding, slot geometry,
// default placement/timing constants and the LFSR seed.
package rex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int SLOTS = 4;
    localparam int POS_W = 16;

    localparam int DEF_SPAWN_X   = 240;
    localparam int DEF_FIRST_X   = 232;
    localparam int DEF_DESPAWN_X = 10;
    localparam int DEF_BASE_STEP = 8;
    localparam int DEF_MIN_GAP   = 6;
    localparam int MAX_STEP      = 16;

    localparam logic [7:0] LFSR_SEED = 8'h5A;

endpackage

// File: rtl/rex_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) with synchronous seed load and advance
// enable; exposes only the low OUT_W bits the consumer needs.
module rex_lfsr8 #(
    parameter logic [7:0] SEED  = 8'h5A,
    parameter int         OUT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             adv,
    output logic [OUT_W-1:0] q
);

    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_ff @(posedge clk) begin
        if (load) begin
            lfsr_reg <= SEED;
        end else if (adv) begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

    assign q = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: four scrolling obstacle slots stepped by a tick divider,
// with pseudo-random spawn spacing. Optional feature macro: OBSTACLE_SPEEDUP_EN.
module obstacle_scheduler
    import rex_pkg::*;
#(
    parameter int DIVISION  = 50,
    parameter int SPAWN_X   = DEF_SPAWN_X,
    parameter int FIRST_X   = DEF_FIRST_X,
    parameter int DESPAWN_X = DEF_DESPAWN_X,
    parameter int BASE_STEP = DEF_BASE_STEP,
    parameter int MIN_GAP   = DEF_MIN_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   clear,
    output logic                   tick,
    output logic [SLOTS*POS_W-1:0] obs_x,
    output logic [SLOTS-1:0]       obs_valid,
    output logic [POS_W-1:0]       near_x,
    output logic                   near_valid,
    output logic [15:0]            score
);

    state_t             state_reg, state_next;
    logic [15:0]        div_cnt_reg;
    logic [7:0]         gap_cnt_reg;
    logic [15:0]        score_reg;
    logic [POS_W-1:0]   x_reg [SLOTS];
    logic [SLOTS-1:0]   valid_reg;
    logic [POS_W-1:0]   x_next [SLOTS];
    logic [SLOTS-1:0]   valid_next;
    logic [POS_W-1:0]   near_x_reg, near_min;
    logic               near_valid_reg, near_any;

    logic [2:0]         lfsr_low;
    logic               tick_now, enter, gap_ok, spawn_go;
    logic [SLOTS-1:0]   free_slots, spawn_sel, keep, despawn;
    logic [POS_W-1:0]   step;
    logic [2:0]         despawn_cnt;
    logic [16:0]        score_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (run)  state_next = ST_RUN;
                ST_RUN:  if (!run) state_next = ST_HALT;
                ST_HALT: if (run)  state_next = ST_RUN;
                default:           state_next = ST_IDLE;
            endcase
        end
    end

    // A tick that coincides with clear is dropped, just like one under reset.
    assign tick     = (state_reg == ST_RUN) && (div_cnt_reg == 16'(DIVISION));
    assign tick_now = tick && !clear;
    assign enter    = (state_reg == ST_IDLE) && run && !clear;

    rex_lfsr8 #(
        .SEED  (LFSR_SEED),
        .OUT_W (3)
    ) u_lfsr (
        .clk  (clk),
        .load (rst || clear),
        .adv  (tick_now),
        .q    (lfsr_low)
    );

`ifdef OBSTACLE_SPEEDUP_EN
    logic [16:0] step_raw;
    assign step_raw = 17'(BASE_STEP) + {4'b0, score_reg[15:3]};
    assign step     = (step_raw > 17'(MAX_STEP)) ? POS_W'(MAX_STEP) : step_raw[POS_W-1:0];
`else
    assign step = POS_W'(BASE_STEP);
`endif

    // Free slots are taken before this tick's despawns, so a freed slot waits a tick.
    assign free_slots = ~valid_reg;
    assign spawn_sel  = free_slots & (~free_slots + SLOTS'(1));
    assign gap_ok     = {1'b0, gap_cnt_reg} >= (9'(MIN_GAP) + {6'b0, lfsr_low});
    assign spawn_go   = tick_now && gap_ok && (|free_slots);

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [POS_W-1:0] slot_x_next;
        logic             slot_valid_next;

        assign keep[gi]    = {1'b0, x_reg[gi]} >= (17'(DESPAWN_X) + {1'b0, step});
        assign despawn[gi] = tick_now && valid_reg[gi] && !keep[gi];

        always_comb begin
            slot_x_next     = x_reg[gi];
            slot_valid_next = valid_reg[gi];
            if (enter) begin
                if (gi == 0) begin
                    slot_x_next     = POS_W'(FIRST_X);
                    slot_valid_next = 1'b1;
                end
            end else if (tick_now) begin
                if (valid_reg[gi]) begin
                    if (keep[gi]) begin
                        slot_x_next = x_reg[gi] - step;
                    end else begin
                        slot_valid_next = 1'b0;
                    end
                end else if (spawn_go && spawn_sel[gi]) begin
                    slot_x_next     = POS_W'(SPAWN_X);
                    slot_valid_next = 1'b1;
                end
            end
        end

        assign x_next[gi]                = slot_x_next;
        assign valid_next[gi]            = slot_valid_next;
        assign obs_x[gi*POS_W +: POS_W]  = x_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < SLOTS; i++) begin
                x_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                x_reg[i] <= x_next[i];
            end
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        despawn_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            despawn_cnt = despawn_cnt + {2'b0, despawn[i]};
        end
    end

    assign score_sum = {1'b0, score_reg} + 17'(despawn_cnt);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            score_reg   <= '0;
        end else if (enter) begin
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else if (tick_now) begin
            div_cnt_reg <= '0;
            if (spawn_go) begin
                gap_cnt_reg <= '0;
            end else if (gap_cnt_reg != 8'hFF) begin
                gap_cnt_reg <= gap_cnt_reg + 8'd1;
            end
            score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end else if (state_reg == ST_RUN) begin
            div_cnt_reg <= div_cnt_reg + 16'd1;
        end
    end

    always_comb begin
        near_min = '1;
        near_any = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_reg[i]) begin
                near_any = 1'b1;
                if (x_reg[i] < near_min) begin
                    near_min = x_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            near_x_reg     <= '1;
            near_valid_reg <= 1'b0;
        end else begin
            near_x_reg     <= near_min;
            near_valid_reg <= near_any;
        end
    end

    assign near_x     = near_x_reg;
    assign near_valid = near_valid_reg;
    assign obs_valid  = valid_reg;
    assign score      = score_reg;

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have the following interface: one clock; reset is synchronous and active-high.
REQ-002 Parameters: DIVISION, default 50, tick divider terminal count. SPAWN_X, default 240, spawn x. FIRST_X, default 232, first obstacle x. DESPAWN_X, default 10, despawn threshold. BASE_STEP, default 8, pixels per tick. MIN_GAP, default 6, minimum ticks between spawns.
REQ-003 Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  high while the game state is go or jump.
- clear  in  1  restart pulse; returns the block to IDLE.
- tick  out  1  one-cycle pulse per movement step.
- obs_x  out  64  four 16-bit slot x positions; slot0 occupies bits [15:0].
- obs_valid  out  4  per-slot occupied flags.
- near_x  out  16  smallest x among valid slots.
- near_valid  out  1  high when any slot is valid.
- score  out  16  count of despawned obstacles.

Function
REQ-004 FSM states: IDLE, RUN, HALT.
REQ-005 IDLE -> RUN when run=1; on that transition, slot0 loads FIRST_X with valid=1 and gap_cnt clears to 0.
REQ-006 RUN -> HALT when run=0; HALT -> RUN when run=1, resuming with no state lost.
REQ-007 clear=1 forces IDLE from any state, overriding run; all slots go invalid, score=0, divider=0.
REQ-008 Divider in RUN only:
- div_cnt increments every cycle.
- When div_cnt==DIVISION, tick=1 and div_cnt=0, giving a period of DIVISION+1 cycles.
- div_cnt holds its value in HALT.
REQ-009 On tick, each valid slot with x >= DESPAWN_X+step SHALL update x <= x-step; otherwise the slot goes invalid and score increments, saturating at 16'hFFFF. x never wraps.
REQ-010 gap_cnt increments on each tick, saturating at 255.
REQ-011 Spawn rule:
- Condition: on a tick with gap_cnt >= MIN_GAP + lfsr[2:0] and at least one slot free, evaluated before this tick's despawns.
- Action: the lowest-index free slot loads SPAWN_X, and gap_cnt=0.
REQ-012 With no free slot, the spawn is deferred to the next tick; gap_cnt keeps counting.
REQ-013 A slot freed by despawn is not reusable in the same tick.
REQ-014 The LFSR advances once per tick and only in RUN.
REQ-015 near_x/near_valid are registered and reflect slot state one cycle after any slot update; near_x=16'hFFFF when near_valid=0.
REQ-016 Slot state is frozen in IDLE and HALT. tick=0 outside RUN.

Reset
REQ-017 rst=1 at a clock edge SHALL force:
- state=IDLE.
- obs_valid=0 and obs_x=0.
- score=0, tick=0.
- near_x=16'hFFFF, near_valid=0.
- div_cnt=0, gap_cnt=0.
- LFSR=8'h5A.
REQ-018 Reset asserted mid-tick discards that tick entirely.

Configuration
REQ-019 Macro OBSTACLE_SPEEDUP_EN, when defined:
- step = BASE_STEP + (score>>3), capped at 16.
- step is sampled at each tick.
REQ-020 Without OBSTACLE_SPEEDUP_EN, step = BASE_STEP constant, and no speed-up logic is synthesized.

Structure
REQ-021 Shared package rex_pkg SHALL hold:
- the FSM state enum.
- the slot count (4) and position width (16).
- the default SPAWN_X, FIRST_X, DESPAWN_X, BASE_STEP and MIN_GAP.
- the LFSR seed.
REQ-022 Sub-module rex_lfsr8: 8-bit Fibonacci LFSR with taps 8,6,5,4, with advance-enable and synchronous seed load.

Verification
REQ-023 rst, then run=1 -> slot0=232 valid the next cycle; first tick at cycle 51 after entry; slot0=224.
REQ-024 Slot at x=17, step 8, tick -> slot invalid, score 0->1, near_valid=0 one cycle later if no other slot is valid.
REQ-025 run=0 for 200 cycles mid-count -> no tick, obs_x unchanged; run=1 -> the next tick arrives after the remaining (DIVISION - div_cnt) cycles.
REQ-026 All 4 slots valid and spawn condition met -> no spawn, gap_cnt keeps incrementing; spawn occurs on the first tick after a slot frees (the tick after despawn).
REQ-027 clear=1 together with run=1 in RUN -> state IDLE, obs_valid=0, score=0 the next cycle.
REQ-028 OBSTACLE_SPEEDUP_EN defined, score forced to 16 via 16 despawns -> per-tick decrement becomes 10; at score>=64 the decrement stays 16.
